// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end for one shared multi-cycle multiplier.
// Grants one requester at a time, holds its operands for the multiplier,
// sequences start/done and returns the 2*WIDTH product on a valid/ready channel.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to bound the wait for done.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 200
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
    output logic                       mul_start_o,
    output logic [WIDTH-1:0]           mul_a_o,
    output logic [WIDTH-1:0]           mul_b_o,
    input  logic                       mul_done_i,
    input  logic [WIDTH-1:0]           mul_lo_i,
    input  logic [WIDTH-1:0]           mul_hi_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic [WIDTH-1:0]           rsp_lo_o,
    output logic [WIDTH-1:0]           rsp_hi_o,
    output logic                       rsp_err_o,
    output logic                       busy_o
);

    localparam int CNT_W = $clog2(SETTLE + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d, id_q, id_d, grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   a_sel, b_sel, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic               found;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
`endif

    // Round-robin pick: first valid at or above rr pointer, then wrap to the low indices
    always_comb begin
        grant    = '0;
        grant_id = '0;
        a_sel    = '0;
        b_sel    = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (i >= int'(rr_q))) begin
                found       = 1'b1;
                grant[i]    = 1'b1;
                grant_id    = ID_W'(i);
                a_sel       = req_a_i[i*WIDTH +: WIDTH];
                b_sel       = req_b_i[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (i < int'(rr_q))) begin
                found       = 1'b1;
                grant[i]    = 1'b1;
                grant_id    = ID_W'(i);
                a_sel       = req_a_i[i*WIDTH +: WIDTH];
                b_sel       = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output computation for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = grant_id;
                    rr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(SETTLE);
`ifdef MULT_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done from a previous op may still be high, so it only counts once settled
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == '0 && mul_done_i) begin
                    lo_d        = mul_lo_i;
                    hi_d        = mul_hi_i;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    lo_d        = '0;
                    hi_d        = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wd_d        = wd_q + WD_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // Accept is combinational from the grant and is forced low while reset is held
    assign req_ready_o = (state_q == S_IDLE && reset_i) ? grant : '0;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_lo_o    = lo_q;
    assign rsp_hi_o    = hi_q;
    assign busy_o      = busy_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err_o   = err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mult_arbiter;
    localparam int N = 4, W = 64, IW = 2, SETTLE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i;
    logic [N-1:0]     req_valid_i, req_ready_o;
    logic [N*W-1:0]   req_a_i, req_b_i;
    logic             mul_start_o, mul_done_i, rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
    logic [W-1:0]     mul_a_o, mul_b_o, mul_lo_i, mul_hi_i, rsp_lo_o, rsp_hi_o;
    logic [IW-1:0]    rsp_id_o;
    logic [2*W-1:0]   prod;

    mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW), .SETTLE(SETTLE), .TIMEOUT(200)) dut (
        .clk(clk), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .mul_start_o(mul_start_o), .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o), .mul_done_i(mul_done_i), .mul_lo_i(mul_lo_i), .mul_hi_i(mul_hi_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_lo_o(rsp_lo_o), .rsp_hi_o(rsp_hi_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o));

    // Multiplier stand-in: true product of held operands, done done_dly cycles after start
    int  dcnt = 0;
    bit  armed = 1'b0;
    int  done_dly = 0;
    bit  done_stuck = 1'b0;
    assign prod = (2*W)'(mul_a_o) * (2*W)'(mul_b_o);
    assign mul_lo_i = prod[W-1:0];
    assign mul_hi_i = prod[2*W-1:W];
    assign mul_done_i = done_stuck | (armed && dcnt == 0);
    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin armed <= 1'b0; dcnt <= 0; end
        else if (mul_start_o) begin armed <= 1'b1; dcnt <= done_dly; end
        else if (armed && dcnt > 0) dcnt <= dcnt - 1;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rr_grant(input logic [N-1:0] v, input int rr);
        logic [N-1:0] g = '0;
        for (int i = 0; i < N; i++)
            if (g == '0 && v[(rr + i) % N]) g[(rr + i) % N] = 1'b1;
        return g;
    endfunction

    // Transaction-level model: one job in flight, k = cycles since its handshake
    int  cyc = 0, k = 0, m_rr = 0, m_id = 0;
    int  grant_cyc = 0, start_cyc = 0, cap_cyc = 0, acc_cyc = 0, txn_cnt = 0, rsp_cnt = 0;
    bit  m_busy = 1'b0, m_got = 1'b0;
    logic [W-1:0] m_a, m_b, last_lo, last_hi;
    int  last_id = -1;
    logic last_err;
    int  gq[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        cyc++;
        if (!reset_i) begin
            chk("rst_ready", req_ready_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_start", mul_start_o, 0);
            chk("rst_mul_a", mul_a_o, 0);
            chk("rst_mul_b", mul_b_o, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_rsp", {rsp_err_o, rsp_id_o, rsp_hi_o, rsp_lo_o}, 0);
            m_busy = 1'b0;
            m_rr = 0;
        end else if (!m_busy) begin
            exp_rdy = rr_grant(req_valid_i, m_rr);
            chk("idle_ready", req_ready_o, exp_rdy);
            chk("idle_busy", busy_o, 0);
            chk("idle_start", mul_start_o, 0);
            chk("idle_rsp_valid", rsp_valid_o, 0);
            if (exp_rdy != '0) begin
                for (int i = 0; i < N; i++) if (exp_rdy[i]) m_id = i;
                m_a = req_a_i[m_id*W +: W];
                m_b = req_b_i[m_id*W +: W];
                m_rr = (m_id + 1) % N;
                gq.push_back(m_id);
                grant_cyc = cyc;
                m_busy = 1'b1;
                m_got = 1'b0;
                k = 0;
                txn_cnt++;
            end
        end else begin
            k++;
            if (mul_start_o) start_cyc = cyc;
            chk("busy_ready", req_ready_o, 0);
            chk("busy_busy", busy_o, 1);
            chk("busy_start", mul_start_o, k == 1);
            chk("hold_mul_a", mul_a_o, m_a);
            chk("hold_mul_b", mul_b_o, m_b);
            chk("rsp_valid", rsp_valid_o, m_got);
            if (m_got) begin
                chk("rsp_id", rsp_id_o, m_id);
                chk("rsp_prod", {rsp_hi_o, rsp_lo_o}, (2*W)'(m_a) * (2*W)'(m_b));
                chk("rsp_err", rsp_err_o, 0);
                if (rsp_ready_i) begin
                    last_id = m_id; last_lo = rsp_lo_o; last_hi = rsp_hi_o; last_err = rsp_err_o;
                    acc_cyc = cyc;
                    rsp_cnt++;
                    m_busy = 1'b0;
                end
            end else if (k >= SETTLE + 2 && mul_done_i) begin
                m_got = 1'b1;
                cap_cyc = cyc;
            end
        end
    end

    task automatic wait_txn(input int target);
        int n = 0;
        while (txn_cnt < target && n < 60) begin @(posedge clk); #1; n++; end
        chk("wait_grant", txn_cnt >= target, 1);
    endtask

    task automatic wait_rsp(input int target, input bit scramble);
        int n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(posedge clk); #1; n++;
            if (scramble)
                for (int j = 0; j < N*W/32; j++) begin
                    req_a_i[j*32 +: 32] = $urandom;
                    req_b_i[j*32 +: 32] = $urandom;
                end
        end
        chk("wait_rsp", rsp_cnt >= target, 1);
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a_i[id*W +: W] = a;
        req_b_i[id*W +: W] = b;
    endtask

    initial begin
        int base;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset_i = 1'b1; req_valid_i = '0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b1;
        #2 reset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b1;

        // single request from requester 1
        set_op(1, 3, 5);
        req_valid_i = 4'b0010;
        wait_txn(1);
        req_valid_i = '0;
        wait_rsp(1, 0);
        chk("t1_id", last_id, 1);
        chk("t1_lo", last_lo, 15);
        chk("t1_hi", last_hi, 0);
        chk("t1_err", last_err, 0);
        chk("t1_start_lat", start_cyc - grant_cyc, 1);
        chk("t1_rsp_lat", cap_cyc + 1 - grant_cyc, 5);

        // all requesters valid from rr=0
        @(posedge clk); #1 reset_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 64'(i + 2), 64'(10*i + 7));
        gq.delete();
        base = rsp_cnt;
        req_valid_i = 4'b1111;
        wait_rsp(base + 5, 0);
        req_valid_i = '0;
        chk("t2_ngrants", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("t2_order", gq[i], exp_order[i]);
        chk("t2_last_id", last_id, 0);
        chk("t2_last_lo", last_lo, 14);

        // operand hold while request inputs churn, slow done
        done_dly = 4;
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        base = txn_cnt;
        req_valid_i = 4'b0100;
        wait_txn(base + 1);
        req_valid_i = '0;
        wait_rsp(rsp_cnt + 1, 1);
        chk("t3_id", last_id, 2);
        chk("t3_hi", last_hi, 1);
        chk("t3_lo", last_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3_rsp_lat", cap_cyc + 1 - grant_cyc, 7);

        // response backpressure with another requester waiting
        done_dly = 0;
        rsp_ready_i = 1'b0;
        set_op(0, 7, 9);
        set_op(3, 11, 13);
        base = txn_cnt;
        req_valid_i = 4'b0001;
        wait_txn(base + 1);
        req_valid_i = 4'b1000;
        for (int n = 0; n < 30 && !m_got; n++) begin @(posedge clk); #1; end
        chk("t4_got", m_got, 1);
        repeat (10) @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        wait_rsp(rsp_cnt + 1, 0);
        chk("t4_id", last_id, 0);
        chk("t4_lo", last_lo, 63);
        wait_txn(base + 2);
        req_valid_i = '0;
        chk("t4_regrant_gap", grant_cyc - acc_cyc, 1);
        wait_rsp(rsp_cnt + 1, 0);
        chk("t4_id2", last_id, 3);
        chk("t4_lo2", last_lo, 143);

        // done stuck high: capture only once the settle window has passed
        done_stuck = 1'b1;
        done_dly = 10;
        set_op(1, 6, 7);
        base = txn_cnt;
        req_valid_i = 4'b0010;
        wait_txn(base + 1);
        req_valid_i = '0;
        wait_rsp(rsp_cnt + 1, 0);
        done_stuck = 1'b0;
        chk("t5_id", last_id, 1);
        chk("t5_lo", last_lo, 42);
        chk("t5_rsp_lat", cap_cyc + 1 - grant_cyc, 5);

        // reset during WAIT aborts the job
        done_dly = 30;
        set_op(0, 5, 5);
        base = txn_cnt;
        req_valid_i = 4'b0001;
        wait_txn(base + 1);
        req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_mul_a", mul_a_o, 0);
        chk("t6_rsp_valid", rsp_valid_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        base = rsp_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_no_rsp", rsp_cnt, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
